// File: rtl/falu_wb_buffer.sv
// falu_wb_buffer: writeback skid FIFO between the FP ALU and the RCU writeback port.
// The FALU cannot be stalled mid-op, so every response is captured here and drained
// under wb_valid_o/wb_ready_i. falu_stall_o tells FP issue to hold off while the
// FIFO is nearly full.
// Optional feature: define FALU_WB_FFLAGS_ACC_EN to add a sticky fflags accumulator
// (ports fflags_acc_o, fflags_acc_clr_i).
module falu_wb_buffer #(
    parameter int unsigned XLEN               = 64,
    parameter int unsigned ROB_INDEX_WIDTH    = 4,
    parameter int unsigned PHY_REG_ADDR_WIDTH = 6,
    parameter int unsigned DEPTH              = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          flush_i,
    input  logic                          falu_valid_i,
    input  logic [XLEN-1:0]               falu_result_i,
    input  logic [PHY_REG_ADDR_WIDTH-1:0] falu_prd_addr_i,
    input  logic [ROB_INDEX_WIDTH-1:0]    falu_rob_index_i,
    input  logic [4:0]                    falu_fflags_i,
    input  logic                          falu_fflags_valid_i,
    output logic                          falu_stall_o,
    output logic                          wb_valid_o,
    input  logic                          wb_ready_i,
    output logic [XLEN-1:0]               wb_result_o,
    output logic [PHY_REG_ADDR_WIDTH-1:0] wb_prd_addr_o,
    output logic [ROB_INDEX_WIDTH-1:0]    wb_rob_index_o,
    output logic [4:0]                    wb_fflags_o,
    output logic                          wb_fflags_valid_o,
`ifdef FALU_WB_FFLAGS_ACC_EN
    input  logic                          fflags_acc_clr_i,
    output logic [4:0]                    fflags_acc_o,
`endif
    output logic                          overflow_err_o
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned PW = AW + 1;
    localparam int unsigned CW = $clog2(DEPTH + 1);

    logic [XLEN-1:0]               result_mem [DEPTH];
    logic [PHY_REG_ADDR_WIDTH-1:0] prd_mem    [DEPTH];
    logic [ROB_INDEX_WIDTH-1:0]    rob_mem    [DEPTH];
    logic [4:0]                    fflags_mem [DEPTH];
    logic                          fv_mem     [DEPTH];

    logic [PW-1:0] wr_ptr, rd_ptr, wr_ptr_next, rd_ptr_next;
    logic [CW-1:0] count, count_next;
    logic          valid_q, stall_q, overflow_q;
    logic          full, deq, enq, drop;
    logic [AW-1:0] head;

    assign head = rd_ptr[AW-1:0];

    // Handshake decode and next pointer/count; flush overrides every update.
    always_comb begin
        full        = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);
        deq         = valid_q & wb_ready_i;
        enq         = falu_valid_i & ~flush_i & (~full | deq);
        drop        = falu_valid_i & ~flush_i & full & ~deq;
        wr_ptr_next = wr_ptr;
        rd_ptr_next = rd_ptr;
        count_next  = count;
        if (flush_i) begin
            wr_ptr_next = '0;
            rd_ptr_next = '0;
            count_next  = '0;
        end else begin
            if (enq) wr_ptr_next = wr_ptr + PW'(1);
            if (deq) rd_ptr_next = rd_ptr + PW'(1);
            case ({enq, deq})
                2'b10:   count_next = count + CW'(1);
                2'b01:   count_next = count - CW'(1);
                default: count_next = count;
            endcase
        end
    end

    // Control state; valid and stall are precomputed from next count so they come straight from flops.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            valid_q    <= 1'b0;
            stall_q    <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            wr_ptr  <= wr_ptr_next;
            rd_ptr  <= rd_ptr_next;
            count   <= count_next;
            valid_q <= (count_next != CW'(0));
            stall_q <= (count_next >= CW'(DEPTH - 1));
            if (drop) overflow_q <= 1'b1;
        end
    end

    // Payload storage; contents are don't-care until written.
    always_ff @(posedge clk) begin
        if (enq) begin
            result_mem[wr_ptr[AW-1:0]] <= falu_result_i;
            prd_mem[wr_ptr[AW-1:0]]    <= falu_prd_addr_i;
            rob_mem[wr_ptr[AW-1:0]]    <= falu_rob_index_i;
            fflags_mem[wr_ptr[AW-1:0]] <= falu_fflags_i;
            fv_mem[wr_ptr[AW-1:0]]     <= falu_fflags_valid_i;
        end
    end

    // Head payload is masked while empty so stale or unreset storage never leaks out.
    assign wb_valid_o        = valid_q;
    assign falu_stall_o      = stall_q;
    assign overflow_err_o    = overflow_q;
    assign wb_result_o       = valid_q ? result_mem[head] : '0;
    assign wb_prd_addr_o     = valid_q ? prd_mem[head]    : '0;
    assign wb_rob_index_o    = valid_q ? rob_mem[head]    : '0;
    assign wb_fflags_valid_o = valid_q & fv_mem[head];
    assign wb_fflags_o       = wb_fflags_valid_o ? fflags_mem[head] : 5'b0;

`ifdef FALU_WB_FFLAGS_ACC_EN
    logic [4:0] acc_q, acc_next;
    logic       acc_take;

    // Accumulate flags of retired entries; a clear in the same cycle keeps only that entry's flags.
    always_comb begin
        acc_take = deq & ~flush_i & wb_fflags_valid_o;
        acc_next = acc_q;
        if (fflags_acc_clr_i) begin
            acc_next = acc_take ? wb_fflags_o : 5'b0;
        end else if (acc_take) begin
            acc_next = acc_q | wb_fflags_o;
        end
    end

    // Accumulator register; only reset clears it, flush leaves it alone.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) acc_q <= 5'b0;
        else     acc_q <= acc_next;
    end

    assign fflags_acc_o = acc_q;
`endif

endmodule

// File: tb/tb_falu_wb_buffer.sv
// Scoreboard bench for falu_wb_buffer: stimulus pushes expected entries,
// a negedge monitor pops and compares on every accepted writeback.
module tb_falu_wb_buffer;

    typedef struct packed {
        logic [63:0] r;
        logic [5:0]  p;
        logic [3:0]  rob;
        logic [4:0]  ff;
        logic        fv;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush_i;
    logic        falu_valid_i;
    logic [63:0] falu_result_i;
    logic [5:0]  falu_prd_addr_i;
    logic [3:0]  falu_rob_index_i;
    logic [4:0]  falu_fflags_i;
    logic        falu_fflags_valid_i;
    logic        falu_stall_o;
    logic        wb_valid_o;
    logic        wb_ready_i;
    logic [63:0] wb_result_o;
    logic [5:0]  wb_prd_addr_o;
    logic [3:0]  wb_rob_index_o;
    logic [4:0]  wb_fflags_o;
    logic        wb_fflags_valid_o;
    logic        overflow_err_o;
`ifdef FALU_WB_FFLAGS_ACC_EN
    logic        fflags_acc_clr_i;
    logic [4:0]  fflags_acc_o;
`endif

    exp_t exp_q[$];
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    falu_wb_buffer dut (
        .clk                 (clk),
        .rst                 (rst),
        .flush_i             (flush_i),
        .falu_valid_i        (falu_valid_i),
        .falu_result_i       (falu_result_i),
        .falu_prd_addr_i     (falu_prd_addr_i),
        .falu_rob_index_i    (falu_rob_index_i),
        .falu_fflags_i       (falu_fflags_i),
        .falu_fflags_valid_i (falu_fflags_valid_i),
        .falu_stall_o        (falu_stall_o),
        .wb_valid_o          (wb_valid_o),
        .wb_ready_i          (wb_ready_i),
        .wb_result_o         (wb_result_o),
        .wb_prd_addr_o       (wb_prd_addr_o),
        .wb_rob_index_o      (wb_rob_index_o),
        .wb_fflags_o         (wb_fflags_o),
        .wb_fflags_valid_o   (wb_fflags_valid_o),
`ifdef FALU_WB_FFLAGS_ACC_EN
        .fflags_acc_clr_i    (fflags_acc_clr_i),
        .fflags_acc_o        (fflags_acc_o),
`endif
        .overflow_err_o      (overflow_err_o)
    );

    task automatic chk(input string name, input logic [95:0] act, input logic [95:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One FALU response for one cycle; push=0 for responses that must be lost.
    task automatic issue(input logic [63:0] r, input logic [5:0] p, input logic [3:0] rob,
                         input logic [4:0] ff, input logic fv, input bit push);
        exp_t e;
        falu_valid_i        = 1'b1;
        falu_result_i       = r;
        falu_prd_addr_i     = p;
        falu_rob_index_i    = rob;
        falu_fflags_i       = ff;
        falu_fflags_valid_i = fv;
        if (push) begin
            e.r   = r;
            e.p   = p;
            e.rob = rob;
            e.ff  = fv ? ff : 5'b0;
            e.fv  = fv;
            exp_q.push_back(e);
        end
        step();
        falu_valid_i = 1'b0;
    endtask

    task automatic wait_drain(input int budget);
        int n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            step();
            n++;
        end
        if (exp_q.size() != 0) begin
            total++;
            bad++;
            $display("FAIL drain_timeout actual=%0d required=0", exp_q.size());
        end
    endtask

    // Monitor: every accepted head must match the oldest expected entry.
    always @(negedge clk) begin
        exp_t e;
        if (!rst && wb_valid_o && wb_ready_i && !flush_i) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_wb actual=rob%0d required=none", wb_rob_index_o);
            end else begin
                e = exp_q.pop_front();
                chk("wb_entry",
                    96'({wb_result_o, wb_prd_addr_o, wb_rob_index_o, wb_fflags_o, wb_fflags_valid_o}),
                    96'({e.r, e.p, e.rob, e.ff, e.fv}));
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst                 = 1'b1;
        flush_i             = 1'b0;
        falu_valid_i        = 1'b0;
        falu_result_i       = '0;
        falu_prd_addr_i     = '0;
        falu_rob_index_i    = '0;
        falu_fflags_i       = '0;
        falu_fflags_valid_i = 1'b0;
        wb_ready_i          = 1'b0;
`ifdef FALU_WB_FFLAGS_ACC_EN
        fflags_acc_clr_i    = 1'b0;
`endif
        step();
        step();
        rst = 1'b0;

        // reset state
        chk("rst_valid", 96'(wb_valid_o), 96'(0));
        chk("rst_stall", 96'(falu_stall_o), 96'(0));
        chk("rst_overflow", 96'(overflow_err_o), 96'(0));
        chk("rst_result", 96'(wb_result_o), 96'(0));

        // 1: single response, visible exactly one cycle later, no comb path
        wb_ready_i = 1'b1;
        begin
            exp_t e;
            falu_valid_i        = 1'b1;
            falu_result_i       = 64'h3FF0_0000_0000_0000;
            falu_prd_addr_i     = 6'd5;
            falu_rob_index_i    = 4'd3;
            falu_fflags_i       = 5'b00010;
            falu_fflags_valid_i = 1'b1;
            e.r = 64'h3FF0_0000_0000_0000; e.p = 6'd5; e.rob = 4'd3; e.ff = 5'b00010; e.fv = 1'b1;
            exp_q.push_back(e);
            #1;
            chk("t1_no_comb_path", 96'(wb_valid_o), 96'(0));
            step();
            falu_valid_i = 1'b0;
        end
        chk("t1_valid_n1", 96'(wb_valid_o), 96'(1));
        chk("t1_result_n1", 96'(wb_result_o), 96'(64'h3FF0_0000_0000_0000));
        step();
        chk("t1_empty_after", 96'(wb_valid_o), 96'(0));

        // 2: fill with ready low, stall at count 3, drain in order
        wb_ready_i = 1'b0;
        issue(64'h0000_0000_0000_1000, 6'd10, 4'd0, 5'b11111, 1'b0, 1'b1);
        chk("t2_stall_c1", 96'(falu_stall_o), 96'(0));
        issue(64'h0000_0000_0000_1001, 6'd11, 4'd1, 5'b00100, 1'b1, 1'b1);
        chk("t2_stall_c2", 96'(falu_stall_o), 96'(0));
        issue(64'h0000_0000_0000_1002, 6'd12, 4'd2, 5'b01000, 1'b1, 1'b1);
        chk("t2_stall_c3", 96'(falu_stall_o), 96'(1));
        issue(64'h0000_0000_0000_1003, 6'd13, 4'd3, 5'b10101, 1'b0, 1'b1);
        chk("t2_stall_c4", 96'(falu_stall_o), 96'(1));
        chk("t2_head_held", 96'(wb_rob_index_o), 96'(0));
        chk("t2_fflags_masked", 96'(wb_fflags_o), 96'(0));
        wb_ready_i = 1'b1;
        step(); step(); step(); step();
        chk("t2_drained", 96'(wb_valid_o), 96'(0));
        chk("t2_stall_off", 96'(falu_stall_o), 96'(0));
        chk("t2_sb_empty", 96'(exp_q.size()), 96'(0));

        // 3: full FIFO, enq and deq in the same cycle
        wb_ready_i = 1'b0;
        issue(64'hC000_0000_0000_0004, 6'd20, 4'd4, 5'b00001, 1'b1, 1'b1);
        issue(64'hC000_0000_0000_0005, 6'd21, 4'd5, 5'b00000, 1'b1, 1'b1);
        issue(64'hC000_0000_0000_0006, 6'd22, 4'd6, 5'b00011, 1'b0, 1'b1);
        issue(64'hC000_0000_0000_0007, 6'd23, 4'd7, 5'b10000, 1'b1, 1'b1);
        wb_ready_i = 1'b1;
        issue(64'hC000_0000_0000_0008, 6'd24, 4'd8, 5'b00110, 1'b1, 1'b1);
        chk("t3_no_overflow", 96'(overflow_err_o), 96'(0));
        chk("t3_still_full", 96'(falu_stall_o), 96'(1));
        wait_drain(10);
        chk("t3_drained", 96'(wb_valid_o), 96'(0));

        // 4: full FIFO, ready low, extra response dropped
        wb_ready_i = 1'b0;
        issue(64'h4000_0000_0000_0009, 6'd30, 4'd9,  5'b00001, 1'b1, 1'b1);
        issue(64'h4000_0000_0000_000A, 6'd31, 4'd10, 5'b00010, 1'b1, 1'b1);
        issue(64'h4000_0000_0000_000B, 6'd32, 4'd11, 5'b00100, 1'b1, 1'b1);
        issue(64'h4000_0000_0000_000C, 6'd33, 4'd12, 5'b01000, 1'b1, 1'b1);
        issue(64'h4000_0000_0000_000D, 6'd34, 4'd13, 5'b10000, 1'b1, 1'b0);
        chk("t4_overflow_set", 96'(overflow_err_o), 96'(1));
        step();
        chk("t4_overflow_sticky", 96'(overflow_err_o), 96'(1));
        chk("t4_head_kept", 96'(wb_rob_index_o), 96'(9));
        wb_ready_i = 1'b1;
        wait_drain(10);
        chk("t4_dropped_gone", 96'(wb_valid_o), 96'(0));

        // 5: flush with 3 entries and a same-cycle response
        wb_ready_i = 1'b0;
        issue(64'h1111_0000_0000_0001, 6'd40, 4'd1, 5'b00001, 1'b1, 1'b1);
        issue(64'h1111_0000_0000_0002, 6'd41, 4'd2, 5'b00010, 1'b1, 1'b1);
        issue(64'h1111_0000_0000_0003, 6'd42, 4'd3, 5'b00100, 1'b1, 1'b1);
        chk("t5_stall_c3", 96'(falu_stall_o), 96'(1));
        flush_i    = 1'b1;
        wb_ready_i = 1'b1;
        issue(64'h1111_0000_0000_000E, 6'd43, 4'd14, 5'b01000, 1'b1, 1'b0);
        exp_q.delete();
        flush_i = 1'b0;
        chk("t5_flush_empty", 96'(wb_valid_o), 96'(0));
        chk("t5_flush_stall", 96'(falu_stall_o), 96'(0));
        chk("t5_flush_result", 96'(wb_result_o), 96'(0));
        step();
        chk("t5_stays_empty", 96'(wb_valid_o), 96'(0));
        issue(64'h2222_0000_0000_000F, 6'd44, 4'd15, 5'b00000, 1'b0, 1'b1);
        wait_drain(10);
        chk("t5_post_flush_ok", 96'(wb_valid_o), 96'(0));
        chk("t5_overflow_kept", 96'(overflow_err_o), 96'(1));

`ifdef FALU_WB_FFLAGS_ACC_EN
        // 6: fflags accumulator
        wb_ready_i       = 1'b0;
        fflags_acc_clr_i = 1'b1;
        step();
        fflags_acc_clr_i = 1'b0;
        chk("t6_acc_cleared", 96'(fflags_acc_o), 96'(0));
        issue(64'h3333_0000_0000_0001, 6'd50, 4'd1, 5'b00001, 1'b1, 1'b1);
        issue(64'h3333_0000_0000_0002, 6'd51, 4'd2, 5'b10000, 1'b1, 1'b1);
        issue(64'h3333_0000_0000_0003, 6'd52, 4'd3, 5'b01000, 1'b0, 1'b1);
        wb_ready_i = 1'b1;
        wait_drain(10);
        step();
        chk("t6_acc_or", 96'(fflags_acc_o), 96'(5'b10001));
        fflags_acc_clr_i = 1'b1;
        step();
        fflags_acc_clr_i = 1'b0;
        chk("t6_acc_clr", 96'(fflags_acc_o), 96'(0));
        wb_ready_i = 1'b0;
        issue(64'h3333_0000_0000_0004, 6'd53, 4'd4, 5'b00100, 1'b1, 1'b1);
        issue(64'h3333_0000_0000_0005, 6'd54, 4'd5, 5'b00010, 1'b1, 1'b1);
        fflags_acc_clr_i = 1'b1;
        wb_ready_i       = 1'b1;
        step();
        fflags_acc_clr_i = 1'b0;
        wb_ready_i       = 1'b0;
        chk("t6_clr_with_deq", 96'(fflags_acc_o), 96'(5'b00100));
        wb_ready_i = 1'b1;
        wait_drain(10);
        step();
        chk("t6_acc_after", 96'(fflags_acc_o), 96'(5'b00110));
`endif

        chk("final_sb_empty", 96'(exp_q.size()), 96'(0));
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
